// File: rtl/design1_cdma_sim_core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : design1_cdma_sim_core_pkg
// Purpose  : Shared definitions for the simple-mode central DMA engine:
//            register offsets, CR/SR bit positions, response codes, FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package design1_cdma_sim_core_pkg;

  // Register byte offsets inside the 256-byte window
  localparam logic [7:0] OFF_CR    = 8'h00;
  localparam logic [7:0] OFF_SR    = 8'h04;
  localparam logic [7:0] OFF_SA_LO = 8'h18;
  localparam logic [7:0] OFF_SA_HI = 8'h1C;
  localparam logic [7:0] OFF_DA_LO = 8'h20;
  localparam logic [7:0] OFF_DA_HI = 8'h24;
  localparam logic [7:0] OFF_BTT   = 8'h28;

  // Control register bits
  localparam int CR_SOFT_RST   = 2;
  localparam int CR_IOC_IRQ_EN = 12;
  localparam int CR_ERR_IRQ_EN = 14;

  // Status register bits
  localparam int SR_IDLE    = 1;
  localparam int SR_INT_ERR = 4;
  localparam int SR_SLV_ERR = 5;
  localparam int SR_DEC_ERR = 6;
  localparam int SR_IOC_IRQ = 12;
  localparam int SR_ERR_IRQ = 14;

  // Memory response encodings
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // One memory beat moves one 64-byte line
  localparam int LINE_BYTES = 64;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Classify a non-OKAY response as {decode error, slave error}.
  // Any unexpected non-zero code is reported as a slave error.
  function automatic logic [1:0] resp_err_bits(input logic [1:0] resp);
    logic [1:0] bits;
    case (resp)
      RESP_OKAY:   bits = 2'b00;
      RESP_DECERR: bits = 2'b10;
      RESP_SLVERR: bits = 2'b01;
      default:     bits = 2'b01;
    endcase
    return bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/design1_cdma_sim_core_regfile.sv
`default_nettype none
// ============================================================================
// Module   : cdma_regfile
// Purpose  : Register decode for the DMA engine: CR/SR/SA/DA/BTT storage,
//            start/alignment qualification, W1C status bits, level irq.
// Revision : 1.0 - initial release
// ============================================================================
module cdma_regfile
  import design1_cdma_sim_core_pkg::*;
#(
  parameter int ADDR_W = 44,
  parameter int BTT_W  = 26
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              s_wr_valid_i,
  input  logic [7:0]        s_wr_addr_i,
  input  logic [31:0]       s_wr_data_i,
  input  logic              s_rd_valid_i,
  input  logic [7:0]        s_rd_addr_i,
  output logic [31:0]       s_rd_data_o,
  input  logic              idle_i,
  input  logic              set_ioc_i,
  input  logic              set_slv_err_i,
  input  logic              set_dec_err_i,
  output logic [ADDR_W-1:0] sa_o,
  output logic [ADDR_W-1:0] da_o,
  output logic              start_o,
  output logic              soft_rst_o,
  output logic              irq_o
);

  localparam int HI_W = ADDR_W - 32;

  logic [31:0]       cr_q;
  logic [ADDR_W-1:0] sa_q, da_q;
  logic [BTT_W-1:0]  btt_q;
  logic              int_err_q, slv_err_q, dec_err_q;
  logic              ioc_irq_q, err_irq_q, irq_q;
  logic [31:0]       rd_data_q, rd_mux;

  logic wr_cr, wr_sr, wr_btt, btt_accept, aligned, set_int_err;
  logic w1c_ioc, w1c_err, set_err;

  assign wr_cr      = s_wr_valid_i && (s_wr_addr_i == OFF_CR);
  assign wr_sr      = s_wr_valid_i && (s_wr_addr_i == OFF_SR);
  assign wr_btt     = s_wr_valid_i && (s_wr_addr_i == OFF_BTT);
  assign soft_rst_o = wr_cr && s_wr_data_i[CR_SOFT_RST];

  // A nonzero BTT write while idle is a start request; it only launches
  // the engine if source, destination and length are all line aligned.
  assign btt_accept  = wr_btt && idle_i && (s_wr_data_i[BTT_W-1:0] != '0);
  assign aligned     = (sa_q[5:0] == 6'd0) && (da_q[5:0] == 6'd0) && (s_wr_data_i[5:0] == 6'd0);
  assign start_o     = btt_accept && aligned;
  assign set_int_err = btt_accept && !aligned;

  assign w1c_ioc = wr_sr && s_wr_data_i[SR_IOC_IRQ];
  assign w1c_err = wr_sr && s_wr_data_i[SR_ERR_IRQ];
  assign set_err = set_int_err || set_slv_err_i || set_dec_err_i;

  // Register storage, sticky error flags, W1C interrupt bits and irq
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cr_q      <= '0;
      sa_q      <= '0;
      da_q      <= '0;
      btt_q     <= '0;
      int_err_q <= 1'b0;
      slv_err_q <= 1'b0;
      dec_err_q <= 1'b0;
      ioc_irq_q <= 1'b0;
      err_irq_q <= 1'b0;
      irq_q     <= 1'b0;
    end else if (soft_rst_o) begin
      cr_q      <= '0;
      sa_q      <= '0;
      da_q      <= '0;
      btt_q     <= '0;
      int_err_q <= 1'b0;
      slv_err_q <= 1'b0;
      dec_err_q <= 1'b0;
      ioc_irq_q <= 1'b0;
      err_irq_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (wr_cr) cr_q <= s_wr_data_i;
      if (s_wr_valid_i && (s_wr_addr_i == OFF_SA_LO)) sa_q[31:0]       <= s_wr_data_i;
      if (s_wr_valid_i && (s_wr_addr_i == OFF_SA_HI)) sa_q[ADDR_W-1:32] <= s_wr_data_i[HI_W-1:0];
      if (s_wr_valid_i && (s_wr_addr_i == OFF_DA_LO)) da_q[31:0]       <= s_wr_data_i;
      if (s_wr_valid_i && (s_wr_addr_i == OFF_DA_HI)) da_q[ADDR_W-1:32] <= s_wr_data_i[HI_W-1:0];
      if (btt_accept) btt_q <= s_wr_data_i[BTT_W-1:0];
      int_err_q <= int_err_q | set_int_err;
      slv_err_q <= slv_err_q | set_slv_err_i;
      dec_err_q <= dec_err_q | set_dec_err_i;
      // A set in the same cycle as a clear wins
      ioc_irq_q <= (ioc_irq_q & ~w1c_ioc) | set_ioc_i;
      err_irq_q <= (err_irq_q & ~w1c_err) | set_err;
      irq_q     <= (ioc_irq_q & cr_q[CR_IOC_IRQ_EN]) | (err_irq_q & cr_q[CR_ERR_IRQ_EN]);
    end
  end

  // Read multiplexer; unmapped offsets read as zero
  always_comb begin
    rd_mux = '0;
    case (s_rd_addr_i)
      OFF_CR:    rd_mux = cr_q;
      OFF_SR: begin
        rd_mux[SR_IDLE]    = idle_i;
        rd_mux[SR_INT_ERR] = int_err_q;
        rd_mux[SR_SLV_ERR] = slv_err_q;
        rd_mux[SR_DEC_ERR] = dec_err_q;
        rd_mux[SR_IOC_IRQ] = ioc_irq_q;
        rd_mux[SR_ERR_IRQ] = err_irq_q;
      end
      OFF_SA_LO: rd_mux = sa_q[31:0];
      OFF_SA_HI: rd_mux[HI_W-1:0] = sa_q[ADDR_W-1:32];
      OFF_DA_LO: rd_mux = da_q[31:0];
      OFF_DA_HI: rd_mux[HI_W-1:0] = da_q[ADDR_W-1:32];
      OFF_BTT:   rd_mux[BTT_W-1:0] = btt_q;
      default:   rd_mux = '0;
    endcase
  end

  // Read data is presented the cycle after the read is accepted
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (s_rd_valid_i) begin
      rd_data_q <= rd_mux;
    end
  end

  assign s_rd_data_o = rd_data_q;
  assign sa_o        = sa_q;
  assign da_o        = da_q;
  assign irq_o       = irq_q;

endmodule
`default_nettype wire

// File: rtl/design1_cdma_sim_core.sv
`default_nettype none
// ============================================================================
// Module   : design1_cdma_sim_core
// Purpose  : Simple-mode central DMA: copies 64-byte lines from a source to a
//            destination region, one read/write pair per line.
// Revision : 1.0 - initial release
// ============================================================================
module design1_cdma_sim_core
  import design1_cdma_sim_core_pkg::*;
#(
  parameter int ADDR_W = 44,
  parameter int LINE_W = 512,
  parameter int BTT_W  = 26
) (
  input  logic              pl0_ref_clk,
  input  logic              pl_gen_reset,
  input  logic              s_wr_valid,
  output logic              s_wr_ready,
  input  logic [7:0]        s_wr_addr,
  input  logic [31:0]       s_wr_data,
  input  logic              s_rd_valid,
  output logic              s_rd_ready,
  input  logic [7:0]        s_rd_addr,
  output logic [31:0]       s_rd_data,
  output logic              m_rd_valid,
  input  logic              m_rd_ready,
  output logic [ADDR_W-1:0] m_rd_addr,
  input  logic              m_rdata_valid,
  input  logic [LINE_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  output logic              m_wr_valid,
  input  logic              m_wr_ready,
  output logic [ADDR_W-1:0] m_wr_addr,
  output logic [LINE_W-1:0] m_wdata,
  input  logic              m_bvalid,
  input  logic [1:0]        m_bresp,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(LINE_BYTES);
  localparam logic [BTT_W-1:0]  CNT_STEP  = BTT_W'(LINE_BYTES);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [BTT_W-1:0]  rem_q, rem_d;
  logic [LINE_W-1:0] line_q, line_d;

  logic [ADDR_W-1:0] sa, da;
  logic              start, soft_rst, idle;
  logic              set_ioc, set_slv_err, set_dec_err;

  assign s_wr_ready = 1'b1;
  assign s_rd_ready = 1'b1;
  assign idle       = (state_q == ST_IDLE);

  cdma_regfile #(
    .ADDR_W (ADDR_W),
    .BTT_W  (BTT_W)
  ) u_regfile (
    .clk_i         (pl0_ref_clk),
    .rst_i         (pl_gen_reset),
    .s_wr_valid_i  (s_wr_valid),
    .s_wr_addr_i   (s_wr_addr),
    .s_wr_data_i   (s_wr_data),
    .s_rd_valid_i  (s_rd_valid),
    .s_rd_addr_i   (s_rd_addr),
    .s_rd_data_o   (s_rd_data),
    .idle_i        (idle),
    .set_ioc_i     (set_ioc),
    .set_slv_err_i (set_slv_err),
    .set_dec_err_i (set_dec_err),
    .sa_o          (sa),
    .da_o          (da),
    .start_o       (start),
    .soft_rst_o    (soft_rst),
    .irq_o         (irq)
  );

  // Transfer FSM next-state, datapath updates and request outputs
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    rem_d       = rem_q;
    line_d      = line_q;
    m_rd_valid  = 1'b0;
    m_wr_valid  = 1'b0;
    set_ioc     = 1'b0;
    set_slv_err = 1'b0;
    set_dec_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d   = sa;
          dst_d   = da;
          rem_d   = s_wr_data[BTT_W-1:0];
          state_d = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        m_rd_valid = 1'b1;
        if (m_rd_ready) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (m_rdata_valid) begin
          if (m_rresp != RESP_OKAY) begin
            {set_dec_err, set_slv_err} = resp_err_bits(m_rresp);
            state_d = ST_IDLE;
          end else begin
            line_d  = m_rdata;
            state_d = ST_WR_REQ;
          end
        end
      end
      ST_WR_REQ: begin
        m_wr_valid = 1'b1;
        if (m_wr_ready) state_d = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (m_bvalid) begin
          if (m_bresp != RESP_OKAY) begin
            {set_dec_err, set_slv_err} = resp_err_bits(m_bresp);
            state_d = ST_IDLE;
          end else begin
            src_d   = src_q + ADDR_STEP;
            dst_d   = dst_q + ADDR_STEP;
            rem_d   = rem_q - CNT_STEP;
            state_d = (rem_q == CNT_STEP) ? ST_DONE : ST_RD_REQ;
          end
        end
      end
      ST_DONE: begin
        set_ioc = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and datapath registers; soft reset drops any outstanding request
  always_ff @(posedge pl0_ref_clk or posedge pl_gen_reset) begin
    if (pl_gen_reset) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      line_q  <= '0;
    end else if (soft_rst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      line_q  <= line_d;
    end
  end

  assign m_rd_addr = src_q;
  assign m_wr_addr = dst_q;
  assign m_wdata   = line_q;

endmodule
`default_nettype wire

// File: tb/tb_design1_cdma_sim_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_design1_cdma_sim_core
// Purpose  : Directed self-checking bench for the central DMA engine with a
//            simple line memory responder that applies random backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module tb_design1_cdma_sim_core;

  localparam int ADDR_W = 44;
  localparam int LINE_W = 512;
  localparam int BTT_W  = 26;

  logic              pl0_ref_clk = 1'b0;
  logic              pl_gen_reset = 1'b1;
  logic              s_wr_valid, s_wr_ready, s_rd_valid, s_rd_ready;
  logic [7:0]        s_wr_addr, s_rd_addr;
  logic [31:0]       s_wr_data, s_rd_data;
  logic              m_rd_valid, m_rd_ready, m_rdata_valid;
  logic [ADDR_W-1:0] m_rd_addr, m_wr_addr;
  logic [LINE_W-1:0] m_rdata, m_wdata;
  logic [1:0]        m_rresp, m_bresp;
  logic              m_wr_valid, m_wr_ready, m_bvalid;
  logic              irq;

  int checks = 0;
  int errors = 0;

  // Responder state
  int                rd_count = 0;
  int                wr_count = 0;
  int                err_at = -1;
  logic [1:0]        err_resp = 2'b10;
  logic              rd_pend = 1'b0, wr_pend = 1'b0, rd_err = 1'b0;
  logic [ADDR_W-1:0] rd_addr, wr_off;
  logic [LINE_W-1:0] dst_mem [0:127];

  // Main-sequence scratch
  int          rb, wb, mism, n;
  logic [31:0] d;

  always #5 pl0_ref_clk = ~pl0_ref_clk;

  design1_cdma_sim_core #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W),
    .BTT_W  (BTT_W)
  ) dut (
    .pl0_ref_clk   (pl0_ref_clk),
    .pl_gen_reset  (pl_gen_reset),
    .s_wr_valid    (s_wr_valid),
    .s_wr_ready    (s_wr_ready),
    .s_wr_addr     (s_wr_addr),
    .s_wr_data     (s_wr_data),
    .s_rd_valid    (s_rd_valid),
    .s_rd_ready    (s_rd_ready),
    .s_rd_addr     (s_rd_addr),
    .s_rd_data     (s_rd_data),
    .m_rd_valid    (m_rd_valid),
    .m_rd_ready    (m_rd_ready),
    .m_rd_addr     (m_rd_addr),
    .m_rdata_valid (m_rdata_valid),
    .m_rdata       (m_rdata),
    .m_rresp       (m_rresp),
    .m_wr_valid    (m_wr_valid),
    .m_wr_ready    (m_wr_ready),
    .m_wr_addr     (m_wr_addr),
    .m_wdata       (m_wdata),
    .m_bvalid      (m_bvalid),
    .m_bresp       (m_bresp),
    .irq           (irq)
  );

  // Source memory content: every 32-bit word holds its own byte address
  function automatic logic [LINE_W-1:0] make_line(input logic [ADDR_W-1:0] a);
    logic [LINE_W-1:0] l;
    for (int k = 0; k < 16; k++) l[32*k +: 32] = a[31:0] + 32'(4 * k);
    return l;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [31:0] v);
    @(negedge pl0_ref_clk);
    s_wr_valid = 1'b1;
    s_wr_addr  = a;
    s_wr_data  = v;
    @(negedge pl0_ref_clk);
    s_wr_valid = 1'b0;
  endtask

  task automatic rd_reg(input logic [7:0] a, output logic [31:0] v);
    @(negedge pl0_ref_clk);
    s_rd_valid = 1'b1;
    s_rd_addr  = a;
    @(negedge pl0_ref_clk);
    s_rd_valid = 1'b0;
    v = s_rd_data;
  endtask

  task automatic wait_irq(input string tag, input int limit);
    int k;
    k = 0;
    while (irq !== 1'b1 && k < limit) begin
      @(negedge pl0_ref_clk);
      k++;
    end
    chk(tag, 64'(irq), 64'd1);
  endtask

  // Memory responder: one-cycle read/write latency, random ready
  initial begin
    m_rd_ready = 1'b0; m_wr_ready = 1'b0;
    m_rdata_valid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
    m_bvalid = 1'b0; m_bresp = 2'b00;
    forever begin
      @(negedge pl0_ref_clk);
      m_rdata_valid = 1'b0;
      m_bvalid      = 1'b0;
      m_rresp       = 2'b00;
      m_bresp       = 2'b00;
      if (rd_pend) begin
        m_rdata_valid = 1'b1;
        m_rdata       = make_line(rd_addr);
        m_rresp       = rd_err ? err_resp : 2'b00;
        rd_pend       = 1'b0;
      end
      if (wr_pend) begin
        m_bvalid = 1'b1;
        wr_pend  = 1'b0;
      end
      m_rd_ready = ($urandom_range(0, 3) != 0);
      m_wr_ready = ($urandom_range(0, 3) != 0);
      if (m_rd_valid && m_rd_ready) begin
        rd_pend = 1'b1;
        rd_addr = m_rd_addr;
        rd_err  = (rd_count == err_at);
        rd_count++;
      end
      if (m_wr_valid && m_wr_ready) begin
        wr_pend = 1'b1;
        wr_count++;
        wr_off = m_wr_addr - 44'h000_1000_0000;
        if (wr_off < 44'h2000) dst_mem[wr_off[12:6]] = m_wdata;
      end
    end
  end

  // Directed sequence
  initial begin
    s_wr_valid = 1'b0; s_wr_addr = '0; s_wr_data = '0;
    s_rd_valid = 1'b0; s_rd_addr = '0;

    // Reset state
    repeat (3) @(negedge pl0_ref_clk);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_rd_valid", 64'(m_rd_valid), 64'd0);
    chk("rst_wr_valid", 64'(m_wr_valid), 64'd0);
    chk("rst_rd_data", 64'(s_rd_data), 64'd0);
    chk("rst_ready", {62'd0, s_wr_ready, s_rd_ready}, 64'd3);
    pl_gen_reset = 1'b0;
    rd_reg(8'h04, d); chk("rst_sr", 64'(d), 64'h2);
    rd_reg(8'h00, d); chk("rst_cr", 64'(d), 64'h0);

    // Unmapped offset
    wr_reg(8'h40, 32'hDEAD_BEEF);
    rd_reg(8'h40, d); chk("unmapped", 64'(d), 64'h0);

    // Main copy: 0x2000 bytes from 0x0 to 0x1000_0000
    wr_reg(8'h00, 32'h0001_7000);
    rd_reg(8'h00, d); chk("cr_rw", 64'(d), 64'h0001_7000);
    wr_reg(8'h18, 32'h0);
    wr_reg(8'h1C, 32'h0);
    wr_reg(8'h20, 32'h1000_0000);
    wr_reg(8'h24, 32'h0);
    rb = rd_count; wb = wr_count;
    wr_reg(8'h28, 32'h2000);
    chk("start_latency", 64'(m_rd_valid), 64'd1);
    wait_irq("copy_irq", 6000);
    chk("copy_reads", 64'(rd_count - rb), 64'd128);
    chk("copy_writes", 64'(wr_count - wb), 64'd128);
    rd_reg(8'h04, d); chk("copy_sr", 64'(d), 64'h1002);
    mism = 0;
    for (int i = 0; i < 128; i++)
      if (dst_mem[i] !== make_line(ADDR_W'(i * 64))) mism++;
    chk("copy_data", 64'(mism), 64'd0);

    // W1C of IOC_Irq: irq follows one cycle after the bit clears
    wr_reg(8'h04, 32'h0000_1000);
    chk("w1c_irq_lag", 64'(irq), 64'd1);
    @(negedge pl0_ref_clk);
    chk("w1c_irq_low", 64'(irq), 64'd0);
    rd_reg(8'h04, d); chk("w1c_sr", 64'(d), 64'h2);

    // Slave error on the third line read
    rb = rd_count; wb = wr_count;
    err_at = rb + 2; err_resp = 2'b10;
    wr_reg(8'h28, 32'h200);
    wait_irq("slverr_irq", 2000);
    err_at = -1;
    repeat (3) @(negedge pl0_ref_clk);
    chk("slverr_reads", 64'(rd_count - rb), 64'd3);
    chk("slverr_writes", 64'(wr_count - wb), 64'd2);
    rd_reg(8'h04, d); chk("slverr_sr", 64'(d), 64'h4022);
    wr_reg(8'h04, 32'h0000_4000);
    @(negedge pl0_ref_clk);
    chk("err_w1c_irq", 64'(irq), 64'd0);

    // Soft reset returns registers to reset values
    wr_reg(8'h00, 32'h0000_0004);
    rd_reg(8'h04, d); chk("softrst_sr", 64'(d), 64'h2);
    rd_reg(8'h00, d); chk("softrst_cr", 64'(d), 64'h0);
    rd_reg(8'h20, d); chk("softrst_da", 64'(d), 64'h0);

    // Unaligned source
    wr_reg(8'h00, 32'h0001_7000);
    wr_reg(8'h18, 32'h20);
    wr_reg(8'h20, 32'h1000_0000);
    rb = rd_count;
    wr_reg(8'h28, 32'h40);
    chk("unal_no_start", 64'(m_rd_valid), 64'd0);
    repeat (20) @(negedge pl0_ref_clk);
    chk("unal_reads", 64'(rd_count - rb), 64'd0);
    chk("unal_irq", 64'(irq), 64'd1);
    rd_reg(8'h04, d); chk("unal_sr", 64'(d), 64'h4012);
    wr_reg(8'h00, 32'h0000_0004);

    // BTT write while busy is ignored
    wr_reg(8'h00, 32'h0001_7000);
    wr_reg(8'h18, 32'h0);
    wr_reg(8'h20, 32'h1000_0000);
    rb = rd_count; wb = wr_count;
    wr_reg(8'h28, 32'h100);
    wr_reg(8'h28, 32'h40);
    wait_irq("busy_irq", 2000);
    chk("busy_reads", 64'(rd_count - rb), 64'd4);
    chk("busy_writes", 64'(wr_count - wb), 64'd4);
    rd_reg(8'h04, d); chk("busy_sr", 64'(d), 64'h1002);
    rd_reg(8'h28, d); chk("busy_btt", 64'(d), 64'h100);
    wr_reg(8'h04, 32'h0000_1000);
    repeat (20) @(negedge pl0_ref_clk);
    chk("busy_one_ioc", 64'(irq), 64'd0);
    rd_reg(8'h04, d); chk("busy_sr_after", 64'(d), 64'h2);

    // Hardware reset while waiting for a write response
    wb = wr_count;
    wr_reg(8'h28, 32'h200);
    n = 0;
    while (wr_count == wb && n < 200) begin
      @(posedge pl0_ref_clk);
      #1;
      n++;
    end
    chk("reach_wr_wait", 64'(wr_count - wb), 64'd1);
    pl_gen_reset = 1'b1;
    #1;
    chk("midrst_rd_valid", 64'(m_rd_valid), 64'd0);
    chk("midrst_wr_valid", 64'(m_wr_valid), 64'd0);
    chk("midrst_irq", 64'(irq), 64'd0);
    chk("midrst_rd_data", 64'(s_rd_data), 64'd0);
    repeat (2) @(negedge pl0_ref_clk);
    pl_gen_reset = 1'b0;
    rd_reg(8'h04, d); chk("midrst_sr", 64'(d), 64'h2);
    rd_reg(8'h00, d); chk("midrst_cr", 64'(d), 64'h0);
    rd_reg(8'h28, d); chk("midrst_btt", 64'(d), 64'h0);
    chk("midrst_idle_rd", 64'(m_rd_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
